// File: rtl/data_memory_responder.sv
// Data-memory responder: accepts one load/store per handshake, applies LATENCY wait
// states against a word-addressed RAM, then holds the response until it is consumed.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | req_ready high (registered), waiting for req_valid
// BUSY   | request latched, wait-state counter running down to zero
// RESP   | resp_valid high, rdata/error held until resp_ready

module data_memory_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2    // legal range 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [3:0]            cnt;

    logic                  lat_write;
    logic                  lat_err;
    logic [DEPTH_LOG2-1:0] lat_idx;
    logic [31:0]           lat_wdata;

    logic [31:0]           mem [DEPTH];

    logic                  accept;
    logic                  done;
    logic                  mem_we;
    logic                  addr_err;
    logic                  resp_fire;

    assign addr_err  = (req_addr[1:0] != 2'b00) ||
                       (req_addr[31:DEPTH_LOG2+2] != '0);
    assign accept    = (state == S_IDLE) && req_valid && req_ready;
    assign done      = (state == S_BUSY) && (cnt == 4'd0);
    assign resp_fire = (state == S_RESP) && resp_ready;
    assign mem_we    = done && lat_write && !lat_err;

    // resp_valid is a pure decode of the state, so reset clears it with the FSM
    assign resp_valid = (state == S_RESP);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept)    state_nxt = S_BUSY;
            S_BUSY: if (done)      state_nxt = S_RESP;
            S_RESP: if (resp_fire) state_nxt = S_IDLE;
            default:               state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            req_ready  <= 1'b0;
            cnt        <= 4'd0;
            lat_write  <= 1'b0;
            lat_err    <= 1'b0;
            lat_idx    <= '0;
            lat_wdata  <= 32'd0;
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            req_ready <= (state_nxt == S_IDLE);

            if (accept) begin
                lat_write <= req_write;
                lat_err   <= addr_err;
                lat_idx   <= req_addr[DEPTH_LOG2+1:2];
                lat_wdata <= req_wdata;
                cnt       <= CNT_LOAD;
            end else if ((state == S_BUSY) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end

            if (done) begin
                resp_error <= lat_err;
                resp_rdata <= (lat_write || lat_err) ? 32'd0 : mem[lat_idx];
            end
        end
    end

    // RAM array is deliberately outside the reset domain: contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[lat_idx] <= lat_wdata;
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized self-checking bench for data_memory_responder; two instances
// (LATENCY=2 and LATENCY=1) are checked against a word-array reference model.

module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_error [2];

    logic [31:0] model_mem [2][256];
    bit          tie_ready [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH_LOG2(8), .LATENCY(2)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0])
    );

    data_memory_responder #(.DEPTH_LOG2(8), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1])
    );

    // One complete transaction, entered and left at a negedge.
    task automatic do_txn(input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold, input bit junk,
                          input string tag);
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          idx;
        int          lat;
        int          lat_exp;
        int          w;
        lat_exp   = (d == 0) ? 2 : 1;
        exp_err   = (addr % 4 != 0) || (addr >= 32'd1024);
        idx       = int'(addr / 4) % 256;
        exp_rdata = (exp_err || wr) ? 32'd0 : model_mem[d][idx];
        if (!exp_err && wr) model_mem[d][idx] = wdata;

        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
        w = 0;
        while (req_ready[d] !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            checks++; errors++;
            $display("FAIL %s ready_timeout: req_ready never rose", tag);
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_write[d] = 1'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        checks++;
        if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_flags: resp_valid=%b req_ready=%b want 0/0",
                     tag, resp_valid[d], req_ready[d]);
        end

        lat = 0;
        while (resp_valid[d] !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks++;
        if (lat != lat_exp) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", tag, lat, lat_exp);
            if (lat >= 40) return;
        end
        checks++;
        if (resp_error[d] !== exp_err || resp_rdata[d] !== exp_rdata) begin
            errors++;
            $display("FAIL %s resp: error=%b rdata=%h want error=%b rdata=%h",
                     tag, resp_error[d], resp_rdata[d], exp_err, exp_rdata);
        end

        for (int h = 0; h < hold; h++) begin
            if (junk) begin
                req_valid[d] = 1'b1;
                req_write[d] = 1'($urandom);
                req_addr[d]  = $urandom_range(0, 255) * 4;
                req_wdata[d] = $urandom;
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (resp_valid[d] !== 1'b1 || req_ready[d] !== 1'b0 ||
                resp_rdata[d] !== exp_rdata || resp_error[d] !== exp_err) begin
                errors++;
                $display("FAIL %s hold%0d: valid=%b ready=%b rdata=%h error=%b want 1/0/%h/%b",
                         tag, h, resp_valid[d], req_ready[d], resp_rdata[d], resp_error[d],
                         exp_rdata, exp_err);
            end
        end

        resp_ready[d] = 1'b1;
        req_valid[d]  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (!tie_ready[d]) resp_ready[d] = 1'b0;
        checks++;
        if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s release: resp_valid=%b req_ready=%b want 0/1",
                     tag, resp_valid[d], req_ready[d]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = 32'd0;
            req_wdata[d] = 32'd0; resp_ready[d] = 1'b0; tie_ready[d] = 1'b0;
        end
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (req_ready[d] !== 1'b0 || resp_valid[d] !== 1'b0 ||
                    resp_rdata[d] !== 32'd0 || resp_error[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_hold dut%0d: ready=%b valid=%b rdata=%h error=%b want 0/0/0/0",
                             d, req_ready[d], resp_valid[d], resp_rdata[d], resp_error[d]);
                end
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_early: req_ready=%b want 0", req_ready[0]);
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_release dut%0d: req_ready=%b want 1", d, req_ready[d]);
            end
        end
    endtask

    task automatic test_fill();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++)
                do_txn(d, 1'b1, i * 4, $urandom, 0, 1'b0, "fill");
    endtask

    task automatic test_store_load();
        do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, "store_10");
        do_txn(0, 1'b0, 32'h10, 32'h0, 0, 1'b0, "load_10");
        checks++;
        if (model_mem[0][4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL model_10: model=%h want deadbeef", model_mem[0][4]);
        end
    endtask

    task automatic test_errors();
        do_txn(0, 1'b0, 32'h12, 32'h0, 0, 1'b0, "load_misaligned");
        do_txn(0, 1'b1, 32'h12, 32'h12345678, 0, 1'b0, "store_misaligned");
        do_txn(0, 1'b1, 32'h400, 32'hCAFEF00D, 0, 1'b0, "store_oor");
        do_txn(0, 1'b0, 32'h0, 32'h0, 0, 1'b0, "load_word0");
        do_txn(0, 1'b0, 32'h8000_0010, 32'h0, 0, 1'b0, "load_oor_high");
        do_txn(0, 1'b0, 32'h10, 32'h0, 0, 1'b0, "load_10_after_err");
    endtask

    task automatic test_hold();
        do_txn(0, 1'b0, 32'h10, 32'h0, 5, 1'b1, "hold_load");
        do_txn(0, 1'b1, 32'h44, 32'h0BAD_CAFE, 5, 1'b1, "hold_store");
        do_txn(0, 1'b0, 32'h44, 32'h0, 2, 1'b0, "hold_readback");
    endtask

    task automatic test_reset_busy();
        logic [31:0] prior;
        prior = model_mem[0][8];
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'h0000_0055;
        req_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_async: valid=%b ready=%b want 0/0", resp_valid[0], req_ready[0]);
        end
        #1 reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (resp_valid[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy_noresp: resp_valid=%b want 0", resp_valid[0]);
            end
        end
        do_txn(0, 1'b0, 32'h20, 32'h0, 0, 1'b0, "reset_busy_readback");
        checks++;
        if (model_mem[0][8] !== prior) begin
            errors++;
            $display("FAIL reset_busy_model: model=%h want %h", model_mem[0][8], prior);
        end
    endtask

    task automatic test_back_to_back();
        tie_ready[1]  = 1'b1;
        resp_ready[1] = 1'b1;
        for (int i = 0; i < 20; i++)
            do_txn(1, 1'b0, $urandom_range(0, 255) * 4, 32'h0, 0, 1'b0, "b2b_load");
        for (int i = 0; i < 6; i++)
            do_txn(1, 1'($urandom), $urandom_range(0, 255) * 4, $urandom, 0, 1'b0, "b2b_mixed");
        tie_ready[1]  = 1'b0;
        resp_ready[1] = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int          sel;
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)
                addr = $urandom_range(0, 255) * 4;
            else if (sel == 7)
                addr = $urandom_range(0, 255) * 4 + $urandom_range(1, 3);
            else
                addr = ($urandom | 32'h400) & 32'hFFFF_FFFC;
            do_txn(i % 2, 1'($urandom), addr, $urandom, $urandom_range(0, 3),
                   1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_store_load();
        test_errors();
        test_hold();
        test_reset_busy();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
